// File: rtl/inst_fetch_if.sv
// Fetch-stage signal bundle: pipeline control, byte-wide instruction memory port
// and the assembled instruction presented to if_id.
interface inst_fetch_if;
   logic        stall_i;
   logic        branch_flag_i;
   logic [31:0] branch_target_i;
   logic        mem_ce_o;
   logic [31:0] mem_addr_o;
   logic        mem_busy_i;
   logic [7:0]  mem_data_i;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        inst_valid_o;

   modport master (
      input  stall_i, branch_flag_i, branch_target_i, mem_busy_i, mem_data_i,
      output mem_ce_o, mem_addr_o, pc_o, inst_o, inst_valid_o
   );

   modport slave (
      output stall_i, branch_flag_i, branch_target_i, mem_busy_i, mem_data_i,
      input  mem_ce_o, mem_addr_o, pc_o, inst_o, inst_valid_o
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: collects a 32-bit little-endian instruction one byte per
// accepted request, then holds it until if_id consumes it or a redirect arrives.
module inst_fetch #(
   parameter logic [31:0] START_ADDR = 32'h00000000,
   parameter logic [31:0] NOP_INST   = 32'h00000013
) (
   input logic          clk,
   input logic          rst,
   inst_fetch_if.master bus
);

   typedef enum logic {FETCH, HOLD} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [1:0]  r_idx;
   logic        r_done;
   logic        r_pend;
   logic [23:0] r_buf;
   logic [31:0] r_inst;
   logic [31:0] r_pc_out;
   logic        r_valid;

   logic        w_req;
   logic        w_acc;
   logic [1:0]  w_pos;

   assign w_req           = (r_state == FETCH) && !r_done;
   assign bus.mem_ce_o    = w_req && !rst;
   assign bus.mem_addr_o  = rst ? '0 : r_pc + {30'd0, r_idx};
   assign w_acc           = bus.mem_ce_o && !bus.mem_busy_i;
   // The in-flight byte is always the one requested just before r_idx advanced.
   assign w_pos           = r_idx - 2'd1;

   assign bus.pc_o         = r_pc_out;
   assign bus.inst_o       = r_inst;
   assign bus.inst_valid_o = r_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= FETCH;
         r_pc     <= START_ADDR;
         r_idx    <= '0;
         r_done   <= 1'b0;
         r_pend   <= 1'b0;
         r_buf    <= '0;
         r_inst   <= NOP_INST;
         r_pc_out <= START_ADDR;
         r_valid  <= 1'b0;
      end else if (bus.branch_flag_i) begin
         r_state <= FETCH;
         r_pc    <= bus.branch_target_i & ~32'd3;
         r_idx   <= '0;
         r_done  <= 1'b0;
         r_pend  <= 1'b0;
         r_inst  <= NOP_INST;
         r_valid <= 1'b0;
      end else begin
         unique case (r_state)
            FETCH: begin
               r_pend <= w_acc;
               if (w_acc) begin
                  r_idx <= r_idx + 2'd1;
                  if (r_idx == 2'd3) r_done <= 1'b1;
               end
               if (r_pend) begin
                  unique case (w_pos)
                     2'd0: r_buf[7:0]   <= bus.mem_data_i;
                     2'd1: r_buf[15:8]  <= bus.mem_data_i;
                     2'd2: r_buf[23:16] <= bus.mem_data_i;
                     2'd3: begin
                        r_state  <= HOLD;
                        r_valid  <= 1'b1;
                        r_inst   <= {bus.mem_data_i, r_buf};
                        r_pc_out <= r_pc;
                     end
                  endcase
               end
            end
            HOLD: begin
               if (!bus.stall_i) begin
                  r_state <= FETCH;
                  r_pc    <= r_pc + 32'd4;
                  r_idx   <= '0;
                  r_done  <= 1'b0;
                  r_pend  <= 1'b0;
                  r_inst  <= NOP_INST;
                  r_valid <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table for the named scenarios, then
// randomized traffic against a transaction-level reference model.
module tb_inst_fetch;

   localparam logic [31:0] START = 32'h00000000;
   localparam logic [31:0] NOP   = 32'h00000013;
   localparam logic [31:0] W0    = 32'h00100513;
   localparam logic [31:0] W4    = 32'h00200593;
   localparam logic [31:0] W100  = 32'h00b506b3;
   localparam logic [31:0] WTOP  = 32'h0000006f;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   inst_fetch_if bus ();

   inst_fetch #(.START_ADDR(START), .NOP_INST(NOP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_err = 0;
   int n_chk = 0;

   typedef struct {
      logic        rst, stall, br;
      logic [31:0] tgt;
      logic        busy;
      logic        ce;
      logic [31:0] addr;
      logic        v;
      logic [31:0] inst, pc;
   } vec_t;
   vec_t vecs[$];

   // Reference model: fetch pointer, number of requests issued, addresses in flight.
   logic [31:0] m_pc;
   int          m_req;
   logic [31:0] m_q[$];
   int          m_got;
   logic        m_hold, m_valid;
   logic [31:0] m_inst, m_pco;
   logic        resp_v;
   logic [31:0] resp_a;

   logic        s_ce, s_v;
   logic [31:0] s_addr, s_inst, s_pc;
   logic        e_ce, e_v;
   logic [31:0] e_addr, e_inst, e_pc;

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'h0: return 8'h13;   32'h1: return 8'h05;
         32'h2: return 8'h10;   32'h3: return 8'h00;
         32'h4: return 8'h93;   32'h5: return 8'h05;
         32'h6: return 8'h20;   32'h7: return 8'h00;
         32'h100: return 8'hb3; 32'h101: return 8'h06;
         32'h102: return 8'hb5; 32'h103: return 8'h00;
         32'hFFFFFFFC: return 8'h6f;
         32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF: return 8'h00;
         default: return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
      endcase
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
   endfunction

   task automatic chk(input string name, input int cyc, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask

   task automatic drive(input logic r, input logic st, input logic b, input logic [31:0] t, input logic bz);
      @(posedge clk);
      #1;
      rst                 = r;
      bus.stall_i         = st;
      bus.branch_flag_i   = b;
      bus.branch_target_i = t;
      bus.mem_busy_i      = bz;
      bus.mem_data_i      = resp_v ? mem_byte(resp_a) : 8'($urandom);
      e_ce   = !r && !m_hold && (m_req < 4);
      e_addr = r ? 32'd0 : m_pc + 32'(m_req);
      e_v    = m_valid;
      e_inst = m_inst;
      e_pc   = m_pco;
      @(negedge clk);
      s_ce   = bus.mem_ce_o;
      s_addr = bus.mem_addr_o;
      s_v    = bus.inst_valid_o;
      s_inst = bus.inst_o;
      s_pc   = bus.pc_o;
   endtask

   task automatic step_model(input logic r, input logic st, input logic b, input logic [31:0] t, input logic bz);
      logic acc;
      acc    = e_ce && !bz;
      resp_v = acc;
      resp_a = e_addr;
      if (r) begin
         m_pc = START; m_req = 0; m_q.delete(); m_got = 0;
         m_hold = 0; m_valid = 0; m_inst = NOP; m_pco = START;
      end else if (b) begin
         m_pc = t & ~32'd3; m_req = 0; m_q.delete(); m_got = 0;
         m_hold = 0; m_valid = 0; m_inst = NOP;
      end else if (m_hold) begin
         if (!st) begin
            m_pc = m_pc + 32'd4; m_req = 0; m_got = 0;
            m_hold = 0; m_valid = 0; m_inst = NOP;
         end
      end else begin
         if (m_q.size() > 0) begin
            void'(m_q.pop_front());
            m_got++;
            if (m_got == 4) begin
               m_hold = 1; m_valid = 1; m_inst = mem_word(m_pc); m_pco = m_pc;
            end
         end
         if (acc) begin
            m_q.push_back(e_addr);
            m_req++;
         end
      end
   endtask

   task automatic compare(input string tag, input int cyc, input logic cr, input logic ce,
                          input logic [31:0] addr, input logic v, input logic [31:0] inst,
                          input logic [31:0] pc);
      chk({tag, ".ce"}, cyc, 32'(s_ce), 32'(ce));
      if (ce || cr) chk({tag, ".addr"}, cyc, s_addr, addr);
      chk({tag, ".valid"}, cyc, 32'(s_v), 32'(v));
      chk({tag, ".inst"}, cyc, s_inst, inst);
      if (v || cr) chk({tag, ".pc"}, cyc, s_pc, pc);
   endtask

   task automatic addv(input logic r, input logic st, input logic b, input logic [31:0] t,
                       input logic bz, input logic ce, input logic [31:0] a, input logic v,
                       input logic [31:0] inst, input logic [31:0] pc);
      vec_t x;
      x.rst = r; x.stall = st; x.br = b; x.tgt = t; x.busy = bz;
      x.ce = ce; x.addr = a; x.v = v; x.inst = inst; x.pc = pc;
      vecs.push_back(x);
   endtask

   task automatic fetch4(input logic [31:0] base);
      for (int unsigned k = 0; k < 4; k++) addv(0, 0, 0, 0, 0, 1, base + k, 0, NOP, 0);
   endtask

   initial begin
      bus.stall_i = 0; bus.branch_flag_i = 0; bus.branch_target_i = '0;
      bus.mem_busy_i = 0; bus.mem_data_i = '0;
      resp_v = 0; resp_a = '0;
      m_pc = START; m_req = 0; m_got = 0; m_hold = 0; m_valid = 0; m_inst = NOP; m_pco = START;

      // Basic fetch, stall in HOLD, consume, next word at 4
      addv(1, 0, 0, 0, 0, 0, 0, 0, NOP, START);
      fetch4(32'h0);
      addv(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0);
      for (int unsigned k = 0; k < 4; k++) addv(0, 1, 0, 0, 0, 0, 0, 1, W0, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 1, W0, 0);
      fetch4(32'h4);
      addv(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0);
      addv(0, 1, 0, 0, 0, 0, 0, 1, W4, 32'h4);
      // Busy for two cycles at byte 2
      addv(1, 0, 0, 0, 0, 0, 0, 1, W4, 32'h4);
      addv(1, 0, 0, 0, 0, 0, 0, 0, NOP, START);
      addv(0, 0, 0, 0, 0, 1, 0, 0, NOP, 0);
      addv(0, 0, 0, 0, 0, 1, 1, 0, NOP, 0);
      addv(0, 0, 0, 0, 1, 1, 2, 0, NOP, 0);
      addv(0, 0, 0, 0, 1, 1, 2, 0, NOP, 0);
      addv(0, 0, 0, 0, 0, 1, 2, 0, NOP, 0);
      addv(0, 0, 0, 0, 0, 1, 3, 0, NOP, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0);
      addv(0, 1, 0, 0, 0, 0, 0, 1, W0, 0);
      // Redirect during byte 1, stale byte must be dropped
      addv(1, 0, 0, 0, 0, 0, 0, 1, W0, 0);
      addv(1, 0, 0, 0, 0, 0, 0, 0, NOP, START);
      addv(0, 0, 0, 0, 0, 1, 0, 0, NOP, 0);
      addv(0, 0, 1, 32'h103, 0, 1, 1, 0, NOP, 0);
      fetch4(32'h100);
      addv(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0);
      addv(0, 1, 0, 0, 0, 0, 0, 1, W100, 32'h100);
      // Redirect together with consume
      addv(1, 0, 0, 0, 0, 0, 0, 1, W100, 32'h100);
      addv(1, 0, 0, 0, 0, 0, 0, 0, NOP, START);
      fetch4(32'h0);
      addv(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0);
      addv(0, 0, 1, 32'h100, 0, 0, 0, 1, W0, 0);
      fetch4(32'h100);
      addv(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0);
      addv(0, 1, 0, 0, 0, 0, 0, 1, W100, 32'h100);
      // Reset mid-fetch, reset wins over branch
      addv(1, 0, 0, 0, 0, 0, 0, 1, W100, 32'h100);
      addv(1, 0, 0, 0, 0, 0, 0, 0, NOP, START);
      addv(0, 0, 0, 0, 0, 1, 0, 0, NOP, 0);
      addv(0, 0, 0, 0, 0, 1, 1, 0, NOP, 0);
      addv(1, 0, 1, 32'h100, 0, 0, 0, 0, NOP, START);
      fetch4(32'h0);
      addv(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0);
      addv(0, 1, 0, 0, 0, 0, 0, 1, W0, 0);
      // PC wrap at the top of the address space
      addv(1, 0, 0, 0, 0, 0, 0, 1, W0, 0);
      addv(1, 0, 0, 0, 0, 0, 0, 0, NOP, START);
      addv(0, 0, 1, 32'hFFFFFFFE, 0, 1, 0, 0, NOP, 0);
      fetch4(32'hFFFFFFFC);
      addv(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 1, WTOP, 32'hFFFFFFFC);
      addv(0, 0, 0, 0, 0, 1, 0, 0, NOP, 0);

      for (int unsigned k = 0; k < 2; k++) begin
         drive(1, 0, 0, 0, 0);
         step_model(1, 0, 0, 0, 0);
      end

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].busy);
         compare("tbl", i, vecs[i].rst, vecs[i].ce, vecs[i].addr, vecs[i].v, vecs[i].inst, vecs[i].pc);
         step_model(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].busy);
      end

      for (int i = 0; i < 4000; i++) begin
         logic r, st, b, bz;
         logic [31:0] t;
         r  = ($urandom_range(0, 199) == 0);
         st = ($urandom_range(0, 1) == 1);
         b  = ($urandom_range(0, 24) == 0);
         bz = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 2))
            0:       t = $urandom;
            1:       t = 32'($urandom_range(0, 511));
            default: t = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
         endcase
         drive(r, st, b, t, bz);
         compare("rnd", i, r, e_ce, e_addr, e_v, e_inst, e_pc);
         step_model(r, st, b, t, bz);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
